prog_clock_divider: RTL and testbench
=====================================

// Module: prog_clock_divider
// PURPOSE
//  Multi-channel programmable clock divider / tick generator for board-level timing (LED blink, scan, debounce strobes).
//  Each channel counts system clocks to a runtime-loadable terminal value.
//  On each terminal count a channel emits a 1-cycle tick and toggles its square-wave output.
//  Sits between the board oscillator and any logic needing slow enables; all outputs are synchronous to clk.
// PARAMETERS
//  NUM_CH       4          number of independent divider channels (1..16)
//  CNT_W        32         counter / divide-value width in bits
//  DEFAULT_DIV  50000000   terminal count loaded into every channel at reset
// PORTS
//  clk          in   1                 system clock; all logic on posedge
//  rst          in   1                 synchronous, active-high reset
//  en           in   NUM_CH            per-channel count enable
//  mode         in   NUM_CH            per-channel output select: 0 = square wave (toggle), 1 = tick pulse
//  load_valid   in   1                 divide-value load request
//  load_ch      in   $clog2(NUM_CH)+1  target channel index
//  load_div     in   CNT_W             new terminal count
//  load_ready   out  1                 block can accept a load this cycle
//  tick         out  NUM_CH            1-cycle pulse at each channel's terminal count
//  led          out  NUM_CH            channel output per mode bit
// BEHAVIOUR
//  - Reset (rst=1 at posedge): cnt[i]=0, div[i]=DEFAULT_DIV, tog[i]=1, tick=0, load_ready=1.
//    led[i] shows tog[i]=1, or 0 for mode=1 channels.
//  - Counting, per channel i, en[i]=1:
//    - cnt[i]==div[i]: cnt[i]<=0, tick[i]<=1 for one cycle, tog[i]<=~tog[i].
//    - Otherwise: cnt[i]<=cnt[i]+1, tick[i]<=0.
//  - Periods: tick period = div+1 cycles; toggle-mode led period = 2*(div+1) cycles.
//  - div=0: tick high every cycle; tog flips every cycle.
//  - en[i]=0: cnt[i] and tog[i] hold; tick[i]=0 from the next edge. Re-enabling resumes from the held count.
//  - led[i] = mode[i] ? tick[i] : tog[i]. Pure output mux with no added latency; mode may change at any time.
//  - Load handshake:
//    - Transfer occurs on a posedge with load_valid && load_ready.
//    - Same edge: div[load_ch]<=load_div, cnt[load_ch]<=0. tog is untouched and no tick is emitted on that edge.
//    - load_ready is 0 for exactly the following cycle (LOAD_BUSY), then returns to 1.
//    - Back-to-back loads therefore complete at most every 2 cycles. load_valid held across LOAD_BUSY is accepted on the next IDLE edge.
//    - Load FSM: IDLE (ready=1) --accept--> LOAD_BUSY (ready=0) --1 cycle--> IDLE. rst forces IDLE.
//    - load_ch >= NUM_CH: the transfer still completes (handshake and busy cycle occur), but no channel changes.
//  - Load and terminal count on the same edge for the target channel: the load wins; cnt=0, no tick, tog unchanged.
//  - Counter widths: cnt compares to div at full CNT_W. cnt never exceeds div, except that a load lowering div below cnt is impossible because a load clears cnt.
//  - rst mid-count or during LOAD_BUSY: all state returns to reset values on that edge, and pending loads are discarded.
// CONFIGURATION
//  SYNC_ALL_EN defined:
//    - Adds input port sync_all (1 bit).
//    - sync_all=1 at a posedge: every cnt[i]<=0, tog[i]<=1 and tick<=0, regardless of en, for phase-aligning all channels.
//    - sync_all together with a load: div is still written; the counter result is 0 either way.
//    - rst has priority over sync_all.
//  SYNC_ALL_EN undefined: no sync_all port; channels align only via rst or per-channel loads.
// TESTING
//  T1 reset: bench DEFAULT_DIV=4, NUM_CH=4, assert rst 2 cycles, then en=4'hF, mode=0.
//     -> led=4'hF at release; first tick on the 5th edge after release.
//     -> led[0] period 10 cycles; load_ready=1.
//  T2 load: load ch1 div=1 while ch0 keeps div=4.
//     -> load_ready=0 one cycle after the transfer.
//     -> ch1 ticks every 2 cycles starting 2 edges after the load; ch0 period unchanged.
//  T3 div=0 and mode: load ch2 div=0, mode[2]=1.
//     -> tick[2]=1 every cycle; led[2]=tick[2].
//     -> Switching mode[2]=0 -> led[2] toggles every cycle.
//  T4 enable hold: deassert en[3] with cnt[3]=2 for 7 cycles, then reassert.
//     -> No tick[3] while disabled; next tick 3 cycles after re-enable; led[3] frozen.
//  T5 collisions:
//     - Load ch0 on its terminal-count edge -> no tick[0], cnt[0]=0, tog[0] unchanged.
//     - load_ch=5 -> handshake completes, no div changes.
//     - rst during LOAD_BUSY -> load_ready=1 next cycle.
//  T6 (SYNC_ALL_EN): channels at mixed counts, pulse sync_all.
//     -> All cnt=0 and led=4'hF next cycle; equal-div channels tick in lockstep afterwards.

Source files
------------

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable tick / square-wave divider with a 2-cycle load handshake.
// Optional SYNC_ALL_EN adds a sync_all input that phase-aligns every channel.

module prog_clock_divider_ch #(
   parameter int          CNT_W       = 32,
   parameter int unsigned DEFAULT_DIV = 50000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             ld,
   input  logic [CNT_W-1:0] ld_div,
   output logic             tick,
   output logic             tog
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         div  <= CNT_W'(DEFAULT_DIV);
         tog  <= 1'b1;
         tick <= 1'b0;
      end else begin
         if (ld) div <= ld_div;
         // a load or sync overrides any terminal count on the same edge
         if (sync || ld) begin
            cnt  <= '0;
            tick <= 1'b0;
            if (sync) tog <= 1'b1;
         end else if (en) begin
            if (cnt == div) begin
               cnt  <= '0;
               tick <= 1'b1;
               tog  <= ~tog;
            end else begin
               cnt  <= cnt + 1'b1;
               tick <= 1'b0;
            end
         end else begin
            tick <= 1'b0;
         end
      end
   end

endmodule

module prog_clock_divider #(
   parameter int          NUM_CH      = 4,
   parameter int          CNT_W       = 32,
   parameter int unsigned DEFAULT_DIV = 50000000
) (
   input  logic                    clk,
   input  logic                    rst,
`ifdef SYNC_ALL_EN
   input  logic                    sync_all,
`endif
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH-1:0]       mode,
   input  logic                    load_valid,
   input  logic [$clog2(NUM_CH):0] load_ch,
   input  logic [CNT_W-1:0]        load_div,
   output logic                    load_ready,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       led
);

   localparam int LCH_W = $clog2(NUM_CH) + 1;

   typedef enum logic {IDLE, LOAD_BUSY} load_st_t;

   load_st_t          st;
   logic              accept;
   logic              sync;
   logic [NUM_CH-1:0] ld_hit;
   logic [NUM_CH-1:0] tog;

`ifdef SYNC_ALL_EN
   assign sync = sync_all;
`else
   assign sync = 1'b0;
`endif

   assign accept = load_valid && load_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         st         <= IDLE;
         load_ready <= 1'b1;
      end else begin
         case (st)
            IDLE: if (accept) begin
               st         <= LOAD_BUSY;
               load_ready <= 1'b0;
            end
            LOAD_BUSY: begin
               st         <= IDLE;
               load_ready <= 1'b1;
            end
            default: begin
               st         <= IDLE;
               load_ready <= 1'b1;
            end
         endcase
      end
   end

   // out-of-range channel indices match no lane, so the handshake completes harmlessly
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign ld_hit[i] = accept && (load_ch == LCH_W'(i));

      prog_clock_divider_ch #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .en     (en[i]),
         .sync   (sync),
         .ld     (ld_hit[i]),
         .ld_div (load_div),
         .tick   (tick[i]),
         .tog    (tog[i])
      );

      assign led[i] = mode[i] ? tick[i] : tog[i];
   end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider (NUM_CH=4, CNT_W=8, DEFAULT_DIV=4).
// Expected values are hand-derived edge counts from reset release.

module tb_prog_clock_divider;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] en = 4'h0;
   logic [3:0] mode = 4'h0;
   logic       load_valid = 1'b0;
   logic [2:0] load_ch = 3'd0;
   logic [7:0] load_div = 8'd0;
   logic       load_ready;
   logic [3:0] tick;
   logic [3:0] led;
`ifdef SYNC_ALL_EN
   logic       sync_all = 1'b0;
`endif

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   prog_clock_divider #(
      .NUM_CH      (4),
      .CNT_W       (8),
      .DEFAULT_DIV (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef SYNC_ALL_EN
      .sync_all   (sync_all),
`endif
      .en         (en),
      .mode       (mode),
      .load_valid (load_valid),
      .load_ch    (load_ch),
      .load_div   (load_div),
      .load_ready (load_ready),
      .tick       (tick),
      .led        (led)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // edges until tick[ch] is seen; -1 if the bound expires
   task automatic wait_tick(input int ch, input int bound, output int n);
      n = -1;
      for (int k = 1; k <= bound; k++) begin
         step();
         if (tick[ch]) begin
            n = k;
            break;
         end
      end
   endtask

   initial begin
      int n;
      logic [3:0] t0v, t1v, t2v;
      logic       a, b, held;

      // T1 reset and default divide
      step(); step();
      chk("rst_tick", tick, 4'h0);
      chk("rst_led", led, 4'hF);
      chk("rst_ready", load_ready, 1);
      rst = 1'b0; en = 4'hF;
      repeat (4) step();
      chk("t1_no_early", tick, 4'h0);
      step();
      chk("t1_first_tick", tick, 4'hF);
      chk("t1_led_toggled", led, 4'h0);
      wait_tick(0, 20, n);
      chk("t1_period", n, 5);
      chk("t1_led_back", led[0], 1);

      // T2 load ch1 div=1
      load_valid = 1'b1; load_ch = 3'd1; load_div = 8'd1;
      step();
      chk("t2_busy", load_ready, 0);
      load_valid = 1'b0;
      t0v = '0; t1v = '0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (k == 0) chk("t2_ready_back", load_ready, 1);
         t0v[k] = tick[0];
         t1v[k] = tick[1];
      end
      chk("t2_ch1_pattern", t1v, 4'b1010);
      chk("t2_ch0_pattern", t0v, 4'b1000);
      wait_tick(0, 20, n);
      chk("t2_ch0_period", n, 5);

      // T3 div=0 and mode mux
      load_valid = 1'b1; load_ch = 3'd2; load_div = 8'd0;
      step();
      load_valid = 1'b0; mode = 4'b0100;
      t2v = '0;
      for (int k = 0; k < 4; k++) begin
         step();
         t2v[k] = tick[2];
      end
      chk("t3_tick_every", t2v, 4'hF);
      chk("t3_led_is_tick", led[2], 1);
      en = 4'b1011;
      step();
      chk("t3_led_mode1_idle", led[2], 0);
      mode = 4'b0000;
      #1;
      chk("t3_led_mode0", led[2], 1);
      en = 4'hF;
      step(); a = led[2];
      step(); b = led[2];
      chk("t3_toggle_every", {a, b}, 2'b01);

      // T4 enable hold on ch3 at cnt=2
      wait_tick(3, 20, n);
      chk("t4_sync", n, 2);
      step(); step();
      en = 4'b0111;
      held = 1'b0;
      for (int k = 0; k < 7; k++) begin
         step();
         held |= tick[3];
         if (k == 6) chk("t4_led_frozen", led[3], 1);
      end
      chk("t4_no_tick", held, 0);
      en = 4'hF;
      wait_tick(3, 20, n);
      chk("t4_resume", n, 3);

      // T5a load ch0 on its terminal-count edge
      wait_tick(0, 20, n);
      chk("t5_sync", n, 3);
      repeat (4) step();
      load_valid = 1'b1; load_ch = 3'd0; load_div = 8'd4;
      step();
      load_valid = 1'b0;
      chk("t5_load_no_tick", tick[0], 0);
      chk("t5_load_tog_kept", led[0], 0);
      wait_tick(0, 20, n);
      chk("t5_load_cleared", n, 5);

      // T5b out-of-range channel
      load_valid = 1'b1; load_ch = 3'd5; load_div = 8'd0;
      step();
      chk("t5_oor_busy", load_ready, 0);
      load_valid = 1'b0;
      step();
      chk("t5_oor_ready", load_ready, 1);
      wait_tick(0, 20, n);
      chk("t5_oor_ch0", n, 3);
      wait_tick(1, 20, n);
      wait_tick(1, 20, n);
      chk("t5_oor_ch1", n, 2);

      // T5c reset during LOAD_BUSY with load_valid still held
      load_valid = 1'b1; load_ch = 3'd3; load_div = 8'd2;
      step();
      chk("t5_rst_busy", load_ready, 0);
      rst = 1'b1;
      step();
      rst = 1'b0; load_valid = 1'b0;
      chk("t5_rst_ready", load_ready, 1);
      chk("t5_rst_tick", tick, 4'h0);
      chk("t5_rst_led", led, 4'hF);
      wait_tick(3, 20, n);
      chk("t5_rst_div", n, 5);

`ifdef SYNC_ALL_EN
      // T6 phase alignment
      en = 4'b0001;
      step(); step();
      en = 4'hF;
      step();
      sync_all = 1'b1;
      step();
      sync_all = 1'b0;
      chk("t6_tick", tick, 4'h0);
      chk("t6_led", led, 4'hF);
      wait_tick(0, 20, n);
      chk("t6_period", n, 5);
      chk("t6_lockstep", tick, 4'hF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
